// File: rtl/cp0.sv
// CP0 system coprocessor: SR/Cause/EPC/PRId, interrupt and exception request
// generation, and mtc0/eret handling for a single-commit-point pipeline.
module cp0 (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_PC,
  input  logic [4:0]  i_ExcCode,
  input  logic        i_BD,
  input  logic [5:0]  i_HWInt,
  input  logic        i_EXLClr,
  output logic [31:0] o_rdata,
  output logic        o_Req,
  output logic [31:0] o_EPC,
  output logic [31:0] o_handlerPC
);

  localparam logic [4:0]  ADDR_SR    = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE = 5'd13;
  localparam logic [4:0]  ADDR_EPC   = 5'd14;
  localparam logic [4:0]  ADDR_PRID  = 5'd15;
  localparam logic [31:0] PRID_VALUE = 32'h1234_5678;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        sr_wr;
  logic        epc_wr;
  logic [31:0] pc_aligned;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_req = (|(i_HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (i_ExcCode != 5'd0) & ~sr_exl;
  assign o_Req   = int_req | exc_req;

  assign sr_wr      = i_we & (i_addr == ADDR_SR);
  assign epc_wr     = i_we & (i_addr == ADDR_EPC);
  assign pc_aligned = {i_PC[31:2], 2'b00};

  assign sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'b00};

  always_comb begin
    o_rdata = 32'd0;
    case (i_addr)
      ADDR_SR:    o_rdata = sr_word;
      ADDR_CAUSE: o_rdata = cause_word;
      ADDR_EPC:   o_rdata = epc;
      ADDR_PRID:  o_rdata = PRID_VALUE;
      default:    o_rdata = 32'd0;
    endcase
  end

  assign o_EPC       = epc;
  assign o_handlerPC = HANDLER_PC;

  // A taken request swallows any mtc0/eret in the same cycle; an SR write
  // overrides a concurrent eret, while an EPC write leaves eret free to act.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
    end else begin
      cause_ip <= i_HWInt;
      if (o_Req) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : i_ExcCode;
        cause_bd  <= i_BD;
        epc       <= i_BD ? (pc_aligned - 32'd4) : pc_aligned;
      end else begin
        if (sr_wr) begin
          sr_im  <= i_wdata[15:10];
          sr_exl <= i_wdata[1];
          sr_ie  <= i_wdata[0];
        end else if (i_EXLClr) begin
          sr_exl <= 1'b0;
        end
        if (epc_wr) begin
          epc <= {i_wdata[31:2], 2'b00};
        end
      end
    end
  end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous reset, active-low; when 0 at a `clk` edge, all registers load their reset values.
REQ-003 SHALL have `i_we`, input, 1 bit: mtc0 write strike.
REQ-004 SHALL have `i_addr`, input, 5 bits: CP0 register number for read and write.
REQ-005 SHALL have `i_wdata`, input, 32 bits: mtc0 write data.
REQ-006 SHALL have `i_PC`, input, 32 bits: PC of the instruction currently in the commit (M) stage.
REQ-007 SHALL have `i_ExcCode`, input, 5 bits: exception code carried down the pipe from fetch; 0 = Int (none), 4 = AdEL.
REQ-008 SHALL have `i_BD`, input, 1 bit: the committing instruction sits in a branch delay slot.
REQ-009 SHALL have `i_HWInt`, input, 6 bits: hardware interrupt lines, level-sensitive.
REQ-010 SHALL have `i_EXLClr`, input, 1 bit: eret commits this cycle.
REQ-011 SHALL have `o_rdata`, output, 32 bits: mfc0 read data (combinational).
REQ-012 SHALL have `o_Req`, output, 1 bit: redirect fetch to the handler and flush the pipe this cycle.
REQ-013 SHALL have `o_EPC`, output, 32 bits: current EPC, the eret target.
REQ-014 SHALL have `o_handlerPC`, output, 32 bits: constant 0x00004180.

Function
REQ-015 SHALL hold SR (reg 12) with fields IM[15:10], EXL[1] and IE[0]; all other SR bits SHALL read 0.
REQ-016 SHALL hold Cause (reg 13) with fields BD[31], IP[15:10] and ExcCode[6:2]; all other Cause bits SHALL read 0.
REQ-017 SHALL hold EPC (reg 14) at 32 bits, and SHALL return the constant 0x12345678 for PRId (reg 15).
REQ-018 SHALL drive `o_rdata` to the addressed register value when `i_addr` is 12..15, and to 0 for any other address.
REQ-019 SHALL compute IntReq = |(i_HWInt & SR.IM) & SR.IE & ~SR.EXL.
REQ-020 SHALL compute ExcReq = (i_ExcCode != 0) & ~SR.EXL.
REQ-021 SHALL drive `o_Req` = IntReq | ExcReq, combinationally in the same cycle.
REQ-022 SHALL give priority to interrupt over exception: when IntReq and ExcReq are both set, Cause.ExcCode SHALL latch 0.
REQ-023 SHALL, on a clock edge with `o_Req` = 1:
- set EXL to 1;
- latch Cause.ExcCode as IntReq ? 0 : i_ExcCode;
- latch Cause.BD from i_BD;
- latch EPC as i_BD ? {i_PC[31:2],2'b00} - 4 : {i_PC[31:2],2'b00}.
REQ-024 SHALL force EPC to word alignment, so a misaligned faulting PC (AdEL) is stored with bits [1:0] = 00.
REQ-025 SHALL sample Cause.IP from i_HWInt on every edge, regardless of `o_Req`, `i_we` or EXL.
REQ-026 SHALL, when `i_we` = 1 and `o_Req` = 0, write i_wdata to SR (IM, EXL, IE fields only) or to EPC ({i_wdata[31:2],2'b00}).
REQ-027 SHALL ignore writes to Cause and PRId, except that Cause.IP still samples i_HWInt per REQ-025.
REQ-028 SHALL clear EXL when `i_EXLClr` = 1 and `o_Req` = 0.
REQ-029 SHALL resolve simultaneous events in priority order: Req > mtc0 > eret.
- When `o_Req` = 1, a concurrent mtc0 or eret in the same cycle SHALL be discarded.
- When mtc0 writes SR.EXL in the same cycle as eret, the mtc0 value SHALL win.
REQ-030 SHALL make a write take effect on `o_rdata` in the cycle after the write edge; there is no write-through bypass.
REQ-031 SHALL never assert `o_Req` for a nested exception while EXL = 1; that exception is dropped.

Reset
REQ-032 SHALL, when `reset` = 0 at an edge, load SR = 0, Cause = 0 and EPC = 0.
- As a result, `o_Req` SHALL be 0 from the next cycle until IE is set or an exception arrives.
REQ-033 SHALL, on a reset asserted mid-handler (EXL = 1), clear EXL and leave no pending state.

Verification
REQ-034 SHALL cover the AdEL case: i_PC = 0x00003002, i_ExcCode = 4, i_BD = 0 -> `o_Req` = 1 the same cycle; next cycle EPC = 0x00003000, Cause = 0x00000010, SR.EXL = 1.
REQ-035 SHALL cover the delay-slot case: i_PC = 0x00003010, i_ExcCode = 4, i_BD = 1 -> EPC = 0x0000300C, Cause[31] = 1.
REQ-036 SHALL cover an interrupt: mtc0 reg12 = 0x00000401, then i_HWInt = 6'b000001 -> `o_Req` = 1, Cause.ExcCode = 0, Cause.IP = 000001, `o_rdata`(reg 12) = 0x00000403 after the edge.
REQ-037 SHALL cover priority and nesting: interrupt enabled as in REQ-036, concurrent i_ExcCode = 4 -> Cause.ExcCode = 0. Next cycle, another i_ExcCode = 4 with EXL = 1 -> `o_Req` = 0 and EPC unchanged.
REQ-038 SHALL cover eret versus Req: EXL = 1, i_EXLClr = 1 -> EXL = 0 next cycle. i_EXLClr = 1 together with `o_Req` = 1 -> EXL stays 1.
REQ-039 SHALL cover reset: `reset` = 0 with EXL = 1 and EPC = 0x3000 -> SR = Cause = EPC = 0 next cycle, `o_Req` = 0, and `o_rdata`(reg 15) = 0x12345678 throughout.
